piece_ctrl: RTL and testbench

PIECE_CTRL -- requirements
Module: piece_ctrl

---
 rtl/piece_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_piece_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_ctrl.sv
// piece_ctrl
// Controls the falling piece of a block-stacking game. It spawns pieces from
// an 8-bit LFSR generator, applies player commands and gravity, hard-drops,
// asks the board store to lock the piece in, and waits for the clear to
// finish. A piece that locks while the board reports overflow ends the game.
//
// Ports
//   clk, rst                      : clock, asynchronous active-high reset
//   btn_left/right/rot/down/drop  : one-cycle debounced command pulses
//   tick                          : one-cycle gravity pulse
//   el, er, eu, edrop             : board permissions for left, right,
//                                   rotate and one-row-down of the piece
//   overflow                      : board reports the piece overlaps the top
//   refresh_done                  : board store finished lock-in and clear
//   x, y                          : origin of the falling piece
//   piece_type                    : current piece type, 1..7
//   dir                           : current rotation
//   next_type                     : preview of the following piece, 1..7
//   refresh                       : one-cycle lock request to the board store
//   game_over                     : high once the game has ended

module piece_ctrl #(
   parameter int         SPAWN_X   = 3,
   parameter int         SPAWN_Y   = 0,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_rot,
   input  logic       btn_down,
   input  logic       btn_drop,
   input  logic       tick,
   input  logic       el,
   input  logic       er,
   input  logic       eu,
   input  logic       edrop,
   input  logic       overflow,
   input  logic       refresh_done,
   output logic [4:0] x,
   output logic [4:0] y,
   output logic [2:0] piece_type,
   output logic [1:0] dir,
   output logic [2:0] next_type,
   output logic       refresh,
   output logic       game_over
);

   typedef enum logic [2:0] {
      S_SPAWN,
      S_FALL,
      S_HARD,
      S_LOCK,
      S_WAIT_CLR,
      S_OVER
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic [4:0] x_q, x_d;
   logic [4:0] y_q, y_d;
   logic [1:0] dir_q, dir_d;
   logic [2:0] type_q, type_d;
   logic [2:0] next_type_q, next_type_d;
   logic       refresh_q, refresh_d;
   logic       ovf_q, ovf_d;

   logic [7:0] lfsr_step;
   logic [2:0] lfsr_piece;

   // Fibonacci LFSR with taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
   // The generator never yields type 0, so a zero candidate is folded onto 1.
   always_comb begin
      lfsr_step  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      lfsr_piece = (lfsr_step[2:0] == 3'd0) ? 3'd1 : lfsr_step[2:0];
   end

   // Next-state and datapath. Everything holds by default; refresh is a
   // single-cycle pulse so it defaults low and is raised only from LOCK.
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      x_d         = x_q;
      y_d         = y_q;
      dir_d       = dir_q;
      type_d      = type_q;
      next_type_d = next_type_q;
      refresh_d   = 1'b0;
      ovf_d       = ovf_q;

      case (state_q)
         S_SPAWN: begin
            x_d         = 5'(SPAWN_X);
            y_d         = 5'(SPAWN_Y);
            dir_d       = 2'd0;
            type_d      = next_type_q;
            lfsr_d      = lfsr_step;
            next_type_d = lfsr_piece;
            state_d     = S_FALL;
         end

         // One command per cycle; the if/else chain encodes the priority and
         // silently drops any lower-priority pulse arriving alongside.
         S_FALL: begin
            if (btn_drop) begin
               state_d = S_HARD;
            end else if (btn_rot) begin
               if (eu) begin
                  dir_d = dir_q + 2'd1;
               end
            end else if (btn_left) begin
               if (el) begin
                  x_d = x_q - 5'd1;
               end
            end else if (btn_right) begin
               if (er) begin
                  x_d = x_q + 5'd1;
               end
            end else if (btn_down || tick) begin
               if (edrop) begin
                  y_d = y_q + 5'd1;
               end else begin
                  state_d = S_LOCK;
               end
            end
         end

         S_HARD: begin
            if (edrop) begin
               y_d = y_q + 5'd1;
            end else begin
               state_d = S_LOCK;
            end
         end

         // Overflow is captured here because the board flags are only valid
         // for the piece position that is being locked in.
         S_LOCK: begin
            refresh_d = 1'b1;
            ovf_d     = overflow;
            state_d   = S_WAIT_CLR;
         end

         S_WAIT_CLR: begin
            if (refresh_done) begin
               state_d = ovf_q ? S_OVER : S_SPAWN;
            end
         end

         S_OVER: begin
            state_d = S_OVER;
         end

         default: begin
            state_d = S_SPAWN;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset to the spawn point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_SPAWN;
         lfsr_q      <= LFSR_SEED;
         x_q         <= 5'(SPAWN_X);
         y_q         <= 5'(SPAWN_Y);
         dir_q       <= 2'd0;
         type_q      <= 3'd1;
         next_type_q <= 3'd1;
         refresh_q   <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         x_q         <= x_d;
         y_q         <= y_d;
         dir_q       <= dir_d;
         type_q      <= type_d;
         next_type_q <= next_type_d;
         refresh_q   <= refresh_d;
         ovf_q       <= ovf_d;
      end
   end

   assign x          = x_q;
   assign y          = y_q;
   assign piece_type = type_q;
   assign dir        = dir_q;
   assign next_type  = next_type_q;
   assign refresh    = refresh_q;
   assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_piece_ctrl.sv
// tb_piece_ctrl
// Drives piece_ctrl with directed scenarios and random command traffic and
// compares every output each cycle against a behavioural game model.

module tb_piece_ctrl;

   localparam int         SX   = 3;
   localparam int         SY   = 0;
   localparam logic [7:0] SEED = 8'hA5;

   localparam int PH_NEW   = 0;
   localparam int PH_MOVE  = 1;
   localparam int PH_SLAM  = 2;
   localparam int PH_STAMP = 3;
   localparam int PH_CLEAR = 4;
   localparam int PH_DEAD  = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0;
   logic       btn_down = 1'b0, btn_drop = 1'b0, tick = 1'b0;
   logic       el = 1'b0, er = 1'b0, eu = 1'b0, edrop = 1'b0, overflow = 1'b0;
   logic       refresh_done = 1'b0;
   logic [4:0] x, y;
   logic [2:0] piece_type, next_type;
   logic [1:0] dir;
   logic       refresh, game_over;

   int nCompared   = 0;
   int nMismatched = 0;

   int         mPhase;
   logic [7:0] mLfsr;
   logic [4:0] mX, mY;
   logic [1:0] mDir;
   logic [2:0] mType, mNext;
   logic       mRefresh, mOvf;

   int         refreshSeen = 0;
   int         zeroTypes   = 0;
   int         spawnCount  = 0;
   logic [7:0] seenType    = 8'h00;

   piece_ctrl #(
      .SPAWN_X  (SX),
      .SPAWN_Y  (SY),
      .LFSR_SEED(SEED)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .btn_rot     (btn_rot),
      .btn_down    (btn_down),
      .btn_drop    (btn_drop),
      .tick        (tick),
      .el          (el),
      .er          (er),
      .eu          (eu),
      .edrop       (edrop),
      .overflow    (overflow),
      .refresh_done(refresh_done),
      .x           (x),
      .y           (y),
      .piece_type  (piece_type),
      .dir         (dir),
      .next_type   (next_type),
      .refresh     (refresh),
      .game_over   (game_over)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      if (observed !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // The generator polynomial x^8+x^6+x^5+x^4+1 as a tap mask on bits 7,5,4,3.
   function automatic logic [7:0] nextRandom(input logic [7:0] v);
      return {v[6:0], ^(v & 8'hB8)};
   endfunction

   function automatic logic [2:0] pieceOf(input logic [7:0] v);
      logic [2:0] c;
      c = v[2:0];
      return (c == 3'd0) ? 3'd1 : c;
   endfunction

   task automatic modelReset();
      mPhase   = PH_NEW;
      mLfsr    = SEED;
      mX       = 5'(SX);
      mY       = 5'(SY);
      mDir     = 2'd0;
      mType    = 3'd1;
      mNext    = 3'd1;
      mRefresh = 1'b0;
      mOvf     = 1'b0;
   endtask

   // Advance the game model by one clock using the inputs currently driven.
   task automatic stepModel();
      mRefresh = 1'b0;
      if (mPhase == PH_NEW) begin
         mLfsr  = nextRandom(mLfsr);
         mType  = mNext;
         mNext  = pieceOf(mLfsr);
         mX     = 5'(SX);
         mY     = 5'(SY);
         mDir   = 2'd0;
         mPhase = PH_MOVE;
         spawnCount++;
      end else if (mPhase == PH_MOVE) begin
         if (btn_drop) mPhase = PH_SLAM;
         else if (btn_rot) mDir = eu ? mDir + 2'd1 : mDir;
         else if (btn_left) mX = el ? mX - 5'd1 : mX;
         else if (btn_right) mX = er ? mX + 5'd1 : mX;
         else if (btn_down || tick) begin
            if (edrop) mY = mY + 5'd1;
            else mPhase = PH_STAMP;
         end
      end else if (mPhase == PH_SLAM) begin
         if (edrop) mY = mY + 5'd1;
         else mPhase = PH_STAMP;
      end else if (mPhase == PH_STAMP) begin
         mRefresh = 1'b1;
         mOvf     = overflow;
         mPhase   = PH_CLEAR;
      end else if (mPhase == PH_CLEAR) begin
         if (refresh_done) mPhase = mOvf ? PH_DEAD : PH_NEW;
      end
   endtask

   task automatic compareAll();
      checkOutput("x", 32'(x), 32'(mX));
      checkOutput("y", 32'(y), 32'(mY));
      checkOutput("dir", 32'(dir), 32'(mDir));
      checkOutput("type", 32'(piece_type), 32'(mType));
      checkOutput("next_type", 32'(next_type), 32'(mNext));
      checkOutput("refresh", 32'(refresh), 32'(mRefresh));
      checkOutput("game_over", 32'(game_over), 32'(mPhase == PH_DEAD));
      if (refresh === 1'b1) refreshSeen++;
      if (piece_type == 3'd0 || next_type == 3'd0) zeroTypes++;
      seenType[piece_type] = 1'b1;
      seenType[next_type]  = 1'b1;
   endtask

   // btns = {drop, rot, left, right, down}; flags = {el, er, eu, edrop, overflow}
   task automatic applyStimulus(input logic [4:0] btns, input logic [4:0] flags, input logic tk, input logic rd);
      @(negedge clk);
      compareAll();
      {btn_drop, btn_rot, btn_left, btn_right, btn_down} = btns;
      {el, er, eu, edrop, overflow} = flags;
      tick         = tk;
      refresh_done = rd;
      stepModel();
   endtask

   // Reset is raised mid-cycle to exercise its asynchronous path, checked
   // while held, and released just before the next rising edge.
   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      {btn_drop, btn_rot, btn_left, btn_right, btn_down} = 5'b0;
      {el, er, eu, edrop, overflow} = 5'b0;
      tick         = 1'b0;
      refresh_done = 1'b0;
      #1;
      modelReset();
      compareAll();
      #3;
      rst = 1'b0;
      stepModel();
   endtask

   initial begin
      logic [2:0] prevNext;
      int         deadCycles;
      int         spawnStart;

      // Spawn after reset, then rotate beats left in the same cycle.
      applyReset();
      applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b0);
      applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b0);
      checkOutput("spawn_x", 32'(x), 32'd3);
      checkOutput("spawn_type", 32'(piece_type), 32'd1);
      applyStimulus(5'b01100, 5'b11110, 1'b0, 1'b0);
      applyStimulus(5'b00100, 5'b01110, 1'b0, 1'b0);
      applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b0);
      checkOutput("rot_wins_dir", 32'(dir), 32'd1);
      checkOutput("blocked_left_x", 32'(x), 32'd3);

      // Hard drop five rows, lock, then buttons while the board clears.
      refreshSeen = 0;
      applyStimulus(5'b10000, 5'b11110, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b0);
      applyStimulus(5'b00000, 5'b11100, 1'b0, 1'b0);
      applyStimulus(5'b11111, 5'b11100, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(5'b11111, 5'b11110, 1'b1, 1'b0);
      checkOutput("hard_drop_y", 32'(y), 32'd5);
      applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b1);
      applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b0);
      checkOutput("one_refresh", 32'(refreshSeen), 32'd1);

      // Gravity lock, clear four cycles later, and the preview becomes current.
      applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b0);
      prevNext = next_type;
      applyStimulus(5'b00000, 5'b11100, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(5'b00000, 5'b11100, 1'b0, 1'b0);
      applyStimulus(5'b00000, 5'b11100, 1'b0, 1'b1);
      applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b0);
      applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b0);
      checkOutput("new_piece_y", 32'(y), 32'd0);
      checkOutput("new_piece_type", 32'(piece_type), 32'(prevNext));

      // Overflow at lock ends the game; nothing moves until reset.
      applyStimulus(5'b00000, 5'b11100, 1'b1, 1'b0);
      applyStimulus(5'b00000, 5'b11101, 1'b0, 1'b0);
      applyStimulus(5'b00000, 5'b11100, 1'b0, 1'b1);
      refreshSeen = 0;
      for (int i = 0; i < 8; i++) applyStimulus(5'b11111, 5'b11110, 1'b1, 1'b1);
      applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b0);
      checkOutput("over_latched", 32'(game_over), 32'd1);
      checkOutput("over_no_refresh", 32'(refreshSeen), 32'd0);
      applyReset();
      applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b0);
      checkOutput("reset_clears_over", 32'(game_over), 32'd0);

      // Random traffic, with occasional resets including mid-drop and mid-clear.
      deadCycles = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(299) == 0 || deadCycles > 20) begin
            applyReset();
            deadCycles = 0;
         end else begin
            applyStimulus(5'($urandom) & 5'($urandom),
                          {1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
                           1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
                           1'($urandom_range(15) == 0)},
                          1'($urandom_range(3) == 0), 1'($urandom_range(2) == 0));
            if (mPhase == PH_DEAD) deadCycles++;
         end
      end

      // Back-to-back pieces to exercise the generator over many spawns.
      applyReset();
      seenType   = 8'h00;
      zeroTypes  = 0;
      spawnStart = spawnCount;
      for (int i = 0; i < 4400; i++) applyStimulus(5'b00000, 5'b11100, 1'b1, 1'b1);
      applyStimulus(5'b00000, 5'b11110, 1'b0, 1'b0);
      checkOutput("spawns_ge_1000", 32'(spawnCount - spawnStart >= 1000), 32'd1);
      checkOutput("no_zero_type", 32'(zeroTypes), 32'd0);
      checkOutput("all_types_seen", 32'(seenType[7:1]), 32'h7F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
